mips_cpu_muldiv: RTL and testbench

Iterative multiply/divide unit owning the architectural HI/LO registers. It replaces the combinational hi/lo path inside mips_cpu_alu. The ALU decodes MULT/MULTU/DIV/DIVU/MTHI/MTLO and issues them here through a start/busy handshake. The pipeline stalls MFHI/MFLO while busy is high.

---
 rtl/mips_cpu_muldiv_pkg.sv | 25 ++
 rtl/mips_cpu_muldiv_step.sv | 42 ++++
 rtl/mips_cpu_muldiv.sv | 211 +++++++++++++++++++++
 tb/tb_mips_cpu_muldiv.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_muldiv_pkg.sv
// Shared types for the MIPS multiply/divide unit: operation codes issued by
// the ALU, the FSM state encoding and a small decode helper.
package mips_cpu_muldiv_pkg;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } muldiv_op_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } muldiv_state_t;

    // True for the two's-complement variants (operands need sign handling).
    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == MULT) || (op == DIV);
    endfunction

endpackage

// File: rtl/mips_cpu_muldiv_step.sv
// One radix-2 iteration of the multiply/divide datapath.
//   Multiply: shift-add over the {acc_hi, acc_lo} accumulator; acc_lo starts
//             as the multiplier and is consumed LSB first.
//   Divide:   restoring shift-subtract; acc_hi is the partial remainder and
//             acc_lo shifts the dividend out while quotient bits shift in.
module mips_cpu_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc_hi_next,
    output logic [WIDTH-1:0] acc_lo_next
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] diff_s;

    // Compute both the add/shift and the trial-subtract result, select by op.
    always_comb begin
        sum_s       = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        shifted_s   = {acc_hi, acc_lo[WIDTH-1]};
        diff_s      = shifted_s - {1'b0, operand};
        acc_hi_next = acc_hi;
        acc_lo_next = acc_lo;
        if (is_div) begin
            if (diff_s[WIDTH] == 1'b0) begin
                acc_hi_next = diff_s[WIDTH-1:0];
                acc_lo_next = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                acc_hi_next = shifted_s[WIDTH-1:0];
                acc_lo_next = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_hi_next = sum_s[WIDTH:1];
            acc_lo_next = {sum_s[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mips_cpu_muldiv.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Operations are issued via start/op and run for WIDTH iterations on
// unsigned magnitudes; the sign is restored in FINISH when HI/LO are written.
// Optional build macro MIPS_CPU_MULDIV_FAST_MULT_EN: MULT/MULTU use a
// single-cycle combinational multiplier and never raise busy.
module mips_cpu_muldiv
    import mips_cpu_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    muldiv_state_t      state_r, state_next;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   acc_hi_r, acc_lo_r, operand_r, a_orig_r;
    logic               is_div_r, neg_q_r, neg_r_r, dbz_r;
    logic [WIDTH-1:0]   hi_r, lo_r;
    logic               busy_r, done_r;

    logic               is_mul_op_s, is_div_op_s, signed_s, a_neg_s, b_neg_s;
    logic [WIDTH-1:0]   a_mag_s, b_mag_s;
    logic [WIDTH-1:0]   step_hi_s, step_lo_s;
    logic [2*WIDTH-1:0] prod_raw_s, prod_fix_s;
    logic [WIDTH-1:0]   fix_hi_s, fix_lo_s;
`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_prod_s;
`endif

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

    // Decode the issued op and take operand magnitudes for signed variants.
    always_comb begin
        is_mul_op_s = (op == MULT) || (op == MULTU);
        is_div_op_s = (op == DIV)  || (op == DIVU);
        signed_s    = op_is_signed(op);
        a_neg_s     = signed_s & a[WIDTH-1];
        b_neg_s     = signed_s & b[WIDTH-1];
        a_mag_s     = a_neg_s ? (-a) : a;
        b_mag_s     = b_neg_s ? (-b) : b;
    end

`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
    // Single-cycle unsigned product of the magnitudes.
    always_comb begin
        fast_prod_s = (2*WIDTH)'(a_mag_s) * (2*WIDTH)'(b_mag_s);
    end
`endif

    mips_cpu_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div      (is_div_r),
        .acc_hi      (acc_hi_r),
        .acc_lo      (acc_lo_r),
        .operand     (operand_r),
        .acc_hi_next (step_hi_s),
        .acc_lo_next (step_lo_s)
    );

    // Sign fix-up of the magnitude result, including divide-by-zero override.
    always_comb begin
        prod_raw_s = {acc_hi_r, acc_lo_r};
        prod_fix_s = neg_q_r ? (-prod_raw_s) : prod_raw_s;
        fix_hi_s   = '0;
        fix_lo_s   = '0;
        if (is_div_r) begin
            if (dbz_r) begin
                fix_lo_s = '1;
                fix_hi_s = a_orig_r;
            end else begin
                fix_lo_s = neg_q_r ? (-acc_lo_r) : acc_lo_r;
                fix_hi_s = neg_r_r ? (-acc_hi_r) : acc_hi_r;
            end
        end else begin
            fix_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_fix_s[WIDTH-1:0];
        end
    end

    // Next-state logic: start wins over flush in IDLE, flush aborts RUN only.
    always_comb begin
        state_next = state_r;
        case (state_r)
            S_IDLE: begin
                if (start && is_div_op_s) begin
                    state_next = S_RUN;
                end else if (start && is_mul_op_s) begin
`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
                    state_next = S_FINISH;
`else
                    state_next = S_RUN;
`endif
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_next = S_IDLE;
                end else if (cnt_r == CNT_W'(WIDTH - 1)) begin
                    state_next = S_FINISH;
                end else begin
                    state_next = S_RUN;
                end
            end
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Datapath: operand latch, iteration, HI/LO write and handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r     <= '0;
            acc_hi_r  <= '0;
            acc_lo_r  <= '0;
            operand_r <= '0;
            a_orig_r  <= '0;
            is_div_r  <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            dbz_r     <= 1'b0;
            hi_r      <= '0;
            lo_r      <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            busy_r <= (state_next == S_RUN) ||
                      ((state_next == S_FINISH) && (state_r == S_RUN));
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        cnt_r <= '0;
                        case (op)
                            MTHI: hi_r <= a;
                            MTLO: lo_r <= a;
                            MULT, MULTU: begin
                                is_div_r  <= 1'b0;
                                dbz_r     <= 1'b0;
                                neg_q_r   <= a_neg_s ^ b_neg_s;
                                neg_r_r   <= 1'b0;
                                operand_r <= a_mag_s;
                                a_orig_r  <= a;
`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
                                acc_hi_r  <= fast_prod_s[2*WIDTH-1:WIDTH];
                                acc_lo_r  <= fast_prod_s[WIDTH-1:0];
`else
                                acc_hi_r  <= '0;
                                acc_lo_r  <= b_mag_s;
`endif
                            end
                            DIV, DIVU: begin
                                is_div_r  <= 1'b1;
                                dbz_r     <= (b == '0);
                                neg_q_r   <= a_neg_s ^ b_neg_s;
                                neg_r_r   <= a_neg_s;
                                operand_r <= b_mag_s;
                                a_orig_r  <= a;
                                acc_hi_r  <= '0;
                                acc_lo_r  <= a_mag_s;
                            end
                            default: ;
                        endcase
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                S_RUN: begin
                    if (!flush) begin
                        acc_hi_r <= step_hi_s;
                        acc_lo_r <= step_lo_s;
                        cnt_r    <= cnt_r + CNT_W'(1);
                    end else begin
                        cnt_r    <= '0;
                    end
                end
                S_FINISH: begin
                    hi_r   <= fix_hi_s;
                    lo_r   <= fix_lo_s;
                    done_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed self-checking bench for mips_cpu_muldiv (default 32-bit build).
module tb_mips_cpu_muldiv;
    import mips_cpu_muldiv_pkg::*;

`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
    localparam int MUL_BUSY = 0;
`else
    localparam int MUL_BUSY = 33;
`endif
    localparam int DIV_BUSY = 33;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;

    mips_cpu_muldiv #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        @(negedge clk);
        start = 1'b0; op = 3'd7;
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                          input int exp_busy);
        int busy_cnt = 0;
        int done_cnt = 0;
        bit partial = 1'b0;
        logic [31:0] ph = hi;
        logic [31:0] pl = lo;
        issue(o, av, bv);
        for (int i = 0; i < 40; i++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) done_cnt++;
            if (busy === 1'b1 && (hi !== ph || lo !== pl)) partial = 1'b1;
            @(negedge clk);
        end
        tests++;
        if (busy_cnt !== exp_busy) begin
            fails++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, exp_busy);
        end
        tests++;
        if (done_cnt !== 1) begin
            fails++; $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt);
        end
        tests++;
        if (partial !== 1'b0) begin
            fails++; $display("FAIL %s hilo_stable_while_busy: got changed expected held", name);
        end
        tests++;
        if (hi !== eh) begin
            fails++; $display("FAIL %s hi: got %08h expected %08h", name, hi, eh);
        end
        tests++;
        if (lo !== el) begin
            fails++; $display("FAIL %s lo: got %08h expected %08h", name, lo, el);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd7; a = '0; b = '0;
        #1;
        tests++;
        if ({hi, lo, busy, done} !== 66'd0) begin
            fails++; $display("FAIL reset_state: got hi=%08h lo=%08h busy=%b done=%b expected all 0", hi, lo, busy, done);
        end
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mthi_mtlo();
        issue(MTHI, 32'hDEADBEEF, 32'h0);
        tests++;
        if (hi !== 32'hDEADBEEF || busy !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL mthi: got hi=%08h busy=%b done=%b expected DEADBEEF 0 0", hi, busy, done);
        end
        issue(MTLO, 32'h00000001, 32'h0);
        tests++;
        if (lo !== 32'h00000001 || hi !== 32'hDEADBEEF || busy !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL mtlo: got hi=%08h lo=%08h busy=%b done=%b expected DEADBEEF 00000001 0 0", hi, lo, busy, done);
        end
    endtask

    task automatic test_arith();
        run_op("multu",     MULTU, 32'h000a0000, 32'h00008000, 32'h00000005, 32'h00000000, MUL_BUSY);
        run_op("divu",      DIVU,  32'h000a0000, 32'h00008000, 32'h00000000, 32'h00000014, DIV_BUSY);
        run_op("mult_neg",  MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_BUSY);
        run_op("mult_minmin", MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MUL_BUSY);
        run_op("div_neg_a", DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_BUSY);
        run_op("div_neg_b", DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DIV_BUSY);
        run_op("div_ovf",   DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_BUSY);
        run_op("divu_zero", DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, DIV_BUSY);
        run_op("div_zero",  DIV,   32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF, DIV_BUSY);
    endtask

    task automatic test_mthi_while_busy();
        logic [31:0] ph = hi;
        int done_cnt = 0;
        issue(DIVU, 32'd100, 32'd7);
        issue(MTHI, 32'h00000055, 32'h0);
        tests++;
        if (hi !== ph) begin
            fails++; $display("FAIL mthi_busy_ignored: got hi=%08h expected %08h", hi, ph);
        end
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) done_cnt++;
            @(negedge clk);
        end
        tests++;
        if (hi !== 32'd2 || lo !== 32'd14 || done_cnt !== 1) begin
            fails++; $display("FAIL mthi_busy_result: got hi=%08h lo=%08h done=%0d expected 00000002 0000000e 1", hi, lo, done_cnt);
        end
    endtask

    task automatic test_flush();
        logic [31:0] ph = hi;
        logic [31:0] pl = lo;
        int done_cnt = 0;
        issue(DIVU, 32'h12345678, 32'd3);
        repeat (9) @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin
            fails++; $display("FAIL flush_pre_busy: got %b expected 1", busy);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        tests++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL flush_busy_drop: got %b expected 0", busy);
        end
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) done_cnt++;
            @(negedge clk);
        end
        tests++;
        if (done_cnt !== 0 || hi !== ph || lo !== pl) begin
            fails++; $display("FAIL flush_no_write: got done=%0d hi=%08h lo=%08h expected 0 %08h %08h", done_cnt, hi, lo, ph, pl);
        end
    endtask

    task automatic test_invalid_op();
        logic [31:0] ph = hi;
        logic [31:0] pl = lo;
        issue(3'd6, 32'hA5A5A5A5, 32'h1);
        repeat (3) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== ph || lo !== pl) begin
            fails++; $display("FAIL invalid_op: got busy=%b done=%b hi=%08h lo=%08h expected 0 0 %08h %08h", busy, done, hi, lo, ph, pl);
        end
    endtask

    task automatic test_reset_mid_run();
        issue(MTLO, 32'h0000BEEF, 32'h0);
        issue(MULTU, 32'd3, 32'd5);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        tests++;
        if ({hi, lo, busy, done} !== 66'd0) begin
            fails++; $display("FAIL reset_mid_run: got hi=%08h lo=%08h busy=%b done=%b expected all 0", hi, lo, busy, done);
        end
        @(negedge clk);
        reset = 1'b0;
        run_op("after_reset", MULTU, 32'd3, 32'd5, 32'd0, 32'd15, MUL_BUSY);
    endtask

    task automatic test_back_to_back();
        run_op("b2b_divu", DIVU, 32'hFFFFFFFF, 32'h00010000, 32'h0000FFFF, 32'h0000FFFF, DIV_BUSY);
        run_op("b2b_multu", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_BUSY);
    endtask

    // Test sequence.
    initial begin
        test_reset();
        test_mthi_mtlo();
        test_arith();
        test_mthi_while_busy();
        test_flush();
        test_invalid_op();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
